// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I datapath types used by the writeback controller and its tag FIFO.
package riscv_32i_defs_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  function automatic logic is_x0(input reg_addr_t r);
    return (r == 5'd0);
  endfunction

endpackage

// File: rtl/reg_wb_tag_fifo.sv
// Synchronous FIFO holding the destination register of each outstanding load, in issue order.
module reg_wb_tag_fifo
  import riscv_32i_defs_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [4:0]                   din,
  output logic [4:0]                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  reg_addr_t          mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // Qualified handshakes and status flags
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == {CNT_W{1'b0}});
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    dout      = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: merges one-cycle ALU results and in-order load returns onto the
// single register-file write port, and tracks registers with an outstanding load.
module reg_wb_ctrl
  import riscv_32i_defs_pkg::*;
#(
  parameter int LD_DEPTH = 4
)
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [4:0]                      alu_rd,
  input  logic [31:0]                     alu_data,
  input  logic                            ld_issue_valid,
  output logic                            ld_issue_ready,
  input  logic [4:0]                      ld_issue_rd,
  input  logic                            ld_resp_valid,
  input  logic [31:0]                     ld_resp_data,
  input  logic [4:0]                      chk_rs1,
  input  logic [4:0]                      chk_rs2,
  output logic                            hazard,
  output logic                            wr_en,
  output logic [4:0]                      wr_reg,
  output logic [31:0]                     wr_data,
  output logic [$clog2(LD_DEPTH+1)-1:0]   ld_outstanding,
  output logic                            err
);

  logic [NUM_REGS-1:0] pending_r;
  logic                ld_wr_r;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  reg_addr_t           head_rd_s;
  logic                ld_push_s;
  logic                ld_pop_s;
  logic                alu_fire_s;
  logic                orphan_s;
  logic                rs1_hz_s;
  logic                rs2_hz_s;

  reg_wb_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_push_s),
    .pop   (ld_pop_s),
    .din   (ld_issue_rd),
    .dout  (head_rd_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (ld_outstanding)
  );

  // Handshakes and decode hazard; readiness uses pre-pop/pre-clear state
  always_comb begin
    ld_issue_ready = !fifo_full_s && !(!is_x0(ld_issue_rd) && pending_r[ld_issue_rd]);
    alu_ready      = !ld_resp_valid && !(!is_x0(alu_rd) && pending_r[alu_rd]);
    ld_push_s      = ld_issue_valid && ld_issue_ready;
    ld_pop_s       = ld_resp_valid && !fifo_empty_s;
    orphan_s       = ld_resp_valid && fifo_empty_s;
    alu_fire_s     = alu_valid && alu_ready;
    rs1_hz_s       = !is_x0(chk_rs1) && (pending_r[chk_rs1] || (wr_en && (wr_reg == chk_rs1)));
    rs2_hz_s       = !is_x0(chk_rs2) && (pending_r[chk_rs2] || (wr_en && (wr_reg == chk_rs2)));
    hazard         = rs1_hz_s || rs2_hz_s;
  end

  // Write-port register, pending scoreboard and sticky orphan error
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NUM_REGS{1'b0}};
      ld_wr_r   <= 1'b0;
      wr_en     <= 1'b0;
      wr_reg    <= 5'd0;
      wr_data   <= 32'd0;
      err       <= 1'b0;
    end else begin
      // A load's pending bit drops at the edge its presented write commits
      if (ld_wr_r && !is_x0(wr_reg)) begin
        pending_r[wr_reg] <= 1'b0;
      end
      if (ld_push_s && !is_x0(ld_issue_rd)) begin
        pending_r[ld_issue_rd] <= 1'b1;
      end
      if (ld_pop_s) begin
        wr_en   <= !is_x0(head_rd_s);
        wr_reg  <= head_rd_s;
        wr_data <= ld_resp_data;
        ld_wr_r <= 1'b1;
      end else if (alu_fire_s) begin
        wr_en   <= !is_x0(alu_rd);
        wr_reg  <= alu_rd;
        wr_data <= alu_data;
        ld_wr_r <= 1'b0;
      end else begin
        wr_en   <= 1'b0;
        ld_wr_r <= 1'b0;
      end
      if (orphan_s) begin
        err <= 1'b1;
      end
    end
  end

endmodule
